// File: rtl/fifo_burst_reader.sv
// Read-side burst engine for the synchronous FIFO: drains i_len words and streams
// them on a valid/ready port, with a 2-entry buffer hiding the FIFO's read latency.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [LEN_WIDTH-1:0]  i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_fifo_ren,
    input  logic                  i_fifo_empty,
    input  logic                  i_fifo_valid,
    input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [LEN_WIDTH-1:0]  issue_left_q, issue_left_d;
    logic [LEN_WIDTH-1:0]  deliver_left_q, deliver_left_d;
    logic                  inflight_q;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];

    logic       pop;
    logic       push;
    logic [2:0] pending;

    assign pop     = o_valid & i_ready;
    // Data returning without a matching outstanding read is stale and dropped.
    assign push    = i_fifo_valid & inflight_q;
    assign pending = {1'b0, occ_q} + {2'b00, inflight_q};

    // Only issue a read when the buffer is guaranteed a free slot for its data.
    assign o_fifo_ren = (state_q == ST_RUN) && (issue_left_q != '0) && !i_fifo_empty
                        && (pending < (3'd2 + {2'b00, pop}));

    assign o_valid = (occ_q != 2'd0);
    assign o_data  = buf_q[0];
    assign o_last  = o_valid && (deliver_left_q == LEN_WIDTH'(1));
    assign o_busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign o_done  = (state_q == ST_DONE);

    always_comb begin
        state_d        = state_q;
        issue_left_d   = issue_left_q;
        deliver_left_d = deliver_left_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    issue_left_d   = i_len;
                    deliver_left_d = i_len;
                    state_d        = (i_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (o_fifo_ren) begin
                    issue_left_d = issue_left_q - LEN_WIDTH'(1);
                end
                if (pop) begin
                    deliver_left_d = deliver_left_q - LEN_WIDTH'(1);
                    if (deliver_left_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Entry 0 is always the head; a pop shifts entry 1 forward.
    always_comb begin
        buf_d[0] = buf_q[0];
        buf_d[1] = buf_q[1];
        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        case ({push, pop})
            2'b10: buf_d[occ_q[0]] = i_fifo_rdata;
            2'b01: buf_d[0] = buf_q[1];
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf_d[0] = i_fifo_rdata;
                end else begin
                    buf_d[0] = buf_q[1];
                    buf_d[1] = i_fifo_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            issue_left_q   <= '0;
            deliver_left_q <= '0;
            inflight_q     <= 1'b0;
            occ_q          <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            issue_left_q   <= issue_left_d;
            deliver_left_q <= deliver_left_d;
            inflight_q     <= o_fifo_ren;
            occ_q          <= occ_d;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                    !(push && !pop && (occ_q == 2'd2)));

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed and randomized bursts against a queue-based FIFO model and a stream
// scoreboard; every comparison is an immediate assertion.
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b1;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_len = '0;
    logic          o_busy, o_done, o_fifo_ren;
    logic          i_fifo_empty = 1'b1;
    logic          i_fifo_valid = 1'b0;
    logic [DW-1:0] i_fifo_rdata = '0;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_last;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_fifo_ren(o_fifo_ren),
        .i_fifo_empty(i_fifo_empty), .i_fifo_valid(i_fifo_valid),
        .i_fifo_rdata(i_fifo_rdata), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_last(o_last)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         acc_cyc[$];

    bit         tracking = 0;
    int         t0, blen, nacc, ndel, first_del, done_cyc, last_hs, ready_mode;
    bit         seen_done, prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    logic       obs_busy, obs_done, obs_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: settle, observe at the falling edge, then model the FIFO.
    task automatic tick();
        logic ren, hs;
        i_fifo_empty = (fifo_q.size() == 0);
        @(negedge i_clk);
        ren = o_fifo_ren;
        hs  = o_valid & i_ready;
        obs_busy = o_busy; obs_done = o_done; obs_valid = o_valid;
        if (ren) chk("ren_while_empty", {31'd0, i_fifo_empty}, 0);
        if (tracking) begin
            if (prev_stall) begin
                chk("hold_valid", o_valid, 1);
                chk("hold_data", o_data, prev_data);
                chk("hold_last", o_last, prev_last);
            end
            if (!seen_done && cyc > t0) chk("busy_in_burst", o_busy, 1);
            if (hs) begin
                if (ndel < exp_q.size()) chk("data", o_data, exp_q[ndel]);
                else chk("extra_word", ndel, exp_q.size());
                chk("last", o_last, (ndel == blen - 1));
                if (ready_mode == 0 && ndel < acc_cyc.size())
                    chk("read_to_out_latency", cyc - acc_cyc[ndel], 2);
                if (ndel == 0) first_del = cyc;
                ndel++;
                last_hs = cyc;
            end
            if (ren) begin
                nacc++;
                acc_cyc.push_back(cyc);
                chk("occ_bound", (nacc - ndel <= 2), 1);
            end
            if (o_done && !seen_done) begin
                seen_done = 1;
                done_cyc  = cyc;
                chk("busy_with_done", o_busy, 1);
            end
            prev_stall = o_valid & ~i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
        end
        cyc++;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        if (ren && fifo_q.size() > 0) begin
            i_fifo_valid = 1'b1;
            i_fifo_rdata = fifo_q.pop_front();
        end else begin
            i_fifo_valid = 1'b0;
            i_fifo_rdata = DW'($urandom);
        end
    endtask

    task automatic begin_burst(input int len, input int mode);
        tracking = 1; t0 = cyc; blen = len; nacc = 0; ndel = 0;
        acc_cyc.delete(); prev_stall = 0; seen_done = 0;
        first_del = -1; done_cyc = -1; last_hs = -1; ready_mode = mode;
        i_start = 1'b1;
        i_len   = LW'(len);
        i_ready = ready_for(mode, 0);
        tick();
    endtask

    // writer: push exp_q words at offsets 2, 6, 10; glitch: re-pulse start during RUN.
    task automatic run_burst(input int len, input int mode, input bit writer, input bit glitch);
        begin_burst(len, mode);
        for (int k = 1; k < 300 && !seen_done; k++) begin
            i_ready = ready_for(mode, k);
            if (glitch && k == 3) begin
                i_start = 1'b1;
                i_len   = LW'(2);
            end
            if (writer && (k == 2 || k == 6 || k == 10)) fifo_q.push_back(exp_q[(k - 2) / 4]);
            tick();
        end
        chk("done_seen", seen_done, 1);
        chk("reads_accepted", nacc, len);
        chk("words_delivered", ndel, len);
        if (len == 0) chk("zero_len_done_cycle", done_cyc - t0, 1);
        else chk("done_after_last", done_cyc - last_hs, 1);
        if (len != 0 && mode == 0 && !writer) chk("first_word_latency", first_del - t0, 3);
        i_ready = 1'b1;
        tick();
        chk("busy_falls", obs_busy, 0);
        chk("done_one_cycle", obs_done, 0);
        tracking = 0;
        $display("burst len=%0d mode=%0d writer=%0d glitch=%0d: %0d reads, %0d words, done at +%0d",
                 len, mode, writer, glitch, nacc, ndel, done_cyc - t0);
    endtask

    task automatic load_exp(input int len);
        exp_q = fifo_q;
        while (exp_q.size() > len) void'(exp_q.pop_back());
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_ren"}, o_fifo_ren, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_data"}, o_data, 0);
        chk({tag, "_last"}, o_last, 0);
    endtask

    initial begin
        int sz, len;
        #2 i_rst_n = 1'b0;
        #1 chk_outputs_zero("reset");
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();

        fifo_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        load_exp(5);
        run_burst(5, 0, 0, 0);

        fifo_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        load_exp(5);
        run_burst(5, 1, 0, 0);

        fifo_q.delete();
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        run_burst(3, 0, 1, 0);

        fifo_q = '{8'h55, 8'h66, 8'h77};
        sz = fifo_q.size();
        exp_q.delete();
        run_burst(0, 0, 0, 0);
        chk("fifo_count_unchanged", fifo_q.size(), sz);

        // Reset in the middle of a 6-word burst.
        fifo_q.delete();
        for (int i = 0; i < 10; i++) fifo_q.push_back(8'h30 + 8'(i));
        load_exp(6);
        begin_burst(6, 0);
        for (int k = 1; k < 50 && ndel < 2; k++) begin
            i_ready = 1'b1;
            tick();
        end
        chk("mid_burst_progress", ndel, 2);
        i_rst_n = 1'b0;
        #1 chk_outputs_zero("async_reset");
        tracking = 0;
        repeat (3) tick();
        i_rst_n = 1'b1;
        i_fifo_valid = 1'b1;
        i_fifo_rdata = 8'hEE;
        tick();
        tick();
        chk("stray_valid_ignored", obs_valid, 0);
        $display("reset mid-burst: %0d words left in FIFO", fifo_q.size());
        load_exp(2);
        run_burst(2, 2, 0, 0);

        fifo_q.delete();
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'hC0 + 8'(i));
        load_exp(5);
        run_burst(5, 0, 0, 1);

        for (int r = 0; r < 4; r++) begin
            fifo_q.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len + 2; i++) fifo_q.push_back(8'($urandom));
            load_exp(len);
            run_burst(len, 2, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
